rcc_div_ramp_ctrl: RTL and testbench
====================================

// Module: rcc_div_ramp_ctrl
// PURPOSE
// - Upstream sequencer for rcc_16_div. Takes a target divide-select code from the
//   RCC register block and drives div_sel one ratio level per step, with a
//   programmable settle time between steps.
// - Prevents large instantaneous frequency jumps, and therefore load-current
//   steps, on the divided clock.
// - Reports busy and done to the register block over a valid/ready request port.
// PARAMETERS
// - SETTLE_CYC  32  i_clk cycles div_sel is held after each change.
//   - Must be >= 17: 1 ratio flop plus up to 16 cycles for the divider to adopt a new ratio.
//   - Legal range 17..255.
// - RAMP_EN  1  1 = step one level at a time; 0 = jump straight to the target level in one step.
// PORTS
// - i_clk      in   1  block clock; the same clock that feeds rcc_16_div.
// - rst        in   1  synchronous, active-high reset.
// - req_valid  in   1  new target request.
// - req_sel    in   3  requested div_sel code (divider encoding).
// - req_ready  out  1  request accepted on a cycle where req_valid & req_ready.
// - hold       in   1  freezes the settle counter; div_sel does not change while it is high.
// - div_sel    out  3  to rcc_16_div.div_sel; registered; canonical codes only.
// - cur_lvl    out  3  current level: 0=/1, 1=/2, 2=/4, 3=/8, 4=/16.
// - busy       out  1  high while a ramp is in progress.
// - done       out  1  one-cycle pulse when the target is reached.
// BEHAVIOUR
// - Code/level map:
//   - 0xx -> lvl 0; output code for lvl 0 is 000.
//   - 100 -> lvl 1, 101 -> lvl 2, 110 -> lvl 3, 111 -> lvl 4.
// - Reset (rst=1 at an edge):
//   - state=IDLE, div_sel=000, cur_lvl=0, busy=0, done=0, settle counter=0.
//   - req_ready=0 while rst is high; requests presented during reset are dropped.
// - States: IDLE and SETTLE. Counter width is clog2(SETTLE_CYC).
// - IDLE:
//   - req_ready=1, busy=0.
//   - On an accepting edge T, tgt_lvl is latched from req_sel.
//   - If tgt==cur: stay IDLE; done=1 during cycle T+1; div_sel unchanged.
//   - Else at edge T: cur_lvl moves +/-1 toward tgt (or jumps to tgt if RAMP_EN=0).
//     div_sel updates from the new level, cnt=SETTLE_CYC-1, state=SETTLE.
// - SETTLE:
//   - req_ready=0, busy=1. Further req_valid is ignored; it is not queued and is lost unless held.
//   - Each edge with hold=0 and cnt!=0: cnt decrements.
//   - hold=1: cnt and div_sel are frozen, indefinitely.
//   - Edge with hold=0 and cnt==0:
//     - cur!=tgt: take the next step and reload cnt=SETTLE_CYC-1.
//     - cur==tgt: go to IDLE; done=1 for exactly one cycle. busy falls on the same edge.
// - Timing: div_sel changes at T, T+S, T+2S, ... where S=SETTLE_CYC.
//   - done is high during cycle T+N*S+1, for N steps.
// - A step never skips a level when RAMP_EN=1. Direction is chosen per step, toward tgt.
// - Reset mid-ramp: immediate return to reset values. div_sel=000 on the next cycle,
//   regardless of the level reached.
// - rst has priority over all other inputs at the same edge.
// - done and req_ready are never high in the same cycle as a step edge of an ongoing ramp.
// TESTING
// - Reset with SETTLE_CYC=32 -> div_sel=000, cur_lvl=0, busy=0, done=0; req_ready=1 the cycle after rst falls.
// - From lvl0, request 111 at T -> div_sel = 100@T, 101@T+32, 110@T+64, 111@T+96; done pulses in cycle T+129; busy high T+1..T+128.
// - From lvl4, request 000 -> div_sel 110, 101, 100, 000, 32 cycles apart; cur_lvl ends at 0; exactly one done pulse.
// - Request 010 while at lvl0 -> no div_sel change; done in cycle T+1; busy stays 0.
// - Ramp 000->111 with hold=1 for 50 cycles during the 2nd settle -> 3rd step is delayed by exactly 50 cycles; req_valid pulses mid-ramp are not accepted.
// - rst asserted at T+40 of the 000->111 ramp -> div_sel=000, busy=0 next cycle, no done pulse; RAMP_EN=0 with 000->111 -> single change to 111 at T, done at T+33.

Source files
------------

// File: rtl/rcc_div_ramp_if.sv
// Request/status bundle between the RCC register block (master) and the
// divide-select ramp sequencer (slave), including the div_sel feed to rcc_16_div.
interface rcc_div_ramp_if;
   logic       req_valid;
   logic [2:0] req_sel;
   logic       req_ready;
   logic       hold;
   logic [2:0] div_sel;
   logic [2:0] cur_lvl;
   logic       busy;
   logic       done;

   modport master (
      output req_valid, req_sel, hold,
      input  req_ready, div_sel, cur_lvl, busy, done
   );

   modport slave (
      input  req_valid, req_sel, hold,
      output req_ready, div_sel, cur_lvl, busy, done
   );
endinterface

// File: rtl/rcc_div_ramp_ctrl.sv
// Ramp sequencer for rcc_16_div: walks div_sel toward a requested ratio one level
// per settle window so the divided clock never jumps by more than one octave at once.
module rcc_div_ramp_ctrl #(
   parameter int SETTLE_CYC = 32,
   parameter bit RAMP_EN    = 1'b1
) (
   input logic           i_clk,
   input logic           rst,
   rcc_div_ramp_if.slave rif
);
   localparam int            CW        = $clog2(SETTLE_CYC);
   localparam logic [CW-1:0] RELOAD    = CW'(SETTLE_CYC - 1);
   localparam logic [0:0]    ST_IDLE   = 1'b0;
   localparam logic [0:0]    ST_SETTLE = 1'b1;

   logic [0:0]    state_r, state_nx;
   logic [CW-1:0] cnt_r, cnt_nx;
   logic [2:0]    lvl_r, lvl_nx;
   logic [2:0]    tgt_r, tgt_nx;
   logic [2:0]    req_lvl;
   logic [2:0]    div_sel_r;
   logic          busy_r, done_r, done_nx, ready_r;

   function automatic logic [2:0] lvl_of(input logic [2:0] code);
      if (code[2]) begin
         return {1'b0, code[1:0]} + 3'd1;
      end else begin
         return 3'd0;
      end
   endfunction

   function automatic logic [2:0] code_of(input logic [2:0] lvl);
      case (lvl)
         3'd0:    return 3'b000;
         3'd1:    return 3'b100;
         3'd2:    return 3'b101;
         3'd3:    return 3'b110;
         3'd4:    return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] step_lvl(input logic [2:0] cur, input logic [2:0] tgt);
      if (!RAMP_EN) begin
         return tgt;
      end else if (tgt > cur) begin
         return cur + 3'd1;
      end else if (tgt < cur) begin
         return cur - 3'd1;
      end else begin
         return cur;
      end
   endfunction

   // Next-state logic; an accept while hold is high parks in SETTLE with an
   // expired counter so the first step waits for hold to drop.
   always_comb begin
      state_nx = state_r;
      cnt_nx   = cnt_r;
      lvl_nx   = lvl_r;
      tgt_nx   = tgt_r;
      done_nx  = 1'b0;
      req_lvl  = lvl_of(rif.req_sel);
      case (state_r)
         ST_IDLE: begin
            if (rif.req_valid && ready_r) begin
               tgt_nx = req_lvl;
               if (req_lvl == lvl_r) begin
                  done_nx = 1'b1;
               end else if (rif.hold) begin
                  state_nx = ST_SETTLE;
                  cnt_nx   = {CW{1'b0}};
               end else begin
                  state_nx = ST_SETTLE;
                  lvl_nx   = step_lvl(lvl_r, req_lvl);
                  cnt_nx   = RELOAD;
               end
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (rif.hold) begin
               cnt_nx = cnt_r;
            end else if (cnt_r != {CW{1'b0}}) begin
               cnt_nx = cnt_r - CW'(1);
            end else if (lvl_r != tgt_r) begin
               lvl_nx = step_lvl(lvl_r, tgt_r);
               cnt_nx = RELOAD;
            end else begin
               state_nx = ST_IDLE;
               done_nx  = 1'b1;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; div_sel is re-encoded from the next level so it
   // moves on the same edge as cur_lvl.
   always_ff @(posedge i_clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CW{1'b0}};
         lvl_r     <= 3'd0;
         tgt_r     <= 3'd0;
         div_sel_r <= 3'b000;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         ready_r   <= 1'b0;
      end else begin
         state_r   <= state_nx;
         cnt_r     <= cnt_nx;
         lvl_r     <= lvl_nx;
         tgt_r     <= tgt_nx;
         div_sel_r <= code_of(lvl_nx);
         busy_r    <= (state_nx == ST_SETTLE);
         done_r    <= done_nx;
         ready_r   <= (state_nx == ST_IDLE);
      end
   end

   assign rif.div_sel   = div_sel_r;
   assign rif.cur_lvl   = lvl_r;
   assign rif.busy      = busy_r;
   assign rif.done      = done_r;
   assign rif.req_ready = ready_r;
endmodule

// File: tb/tb_rcc_div_ramp_ctrl.sv
// Bench for rcc_div_ramp_ctrl: directed timing scenarios plus a random run, with a
// per-edge behavioural model for a ramping (S=32) and a jumping (S=17) instance.
module tb_rcc_div_ramp_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic [2:0] req_sel = 3'd0;
   logic       hold = 1'b0;

   int n_chk = 0;
   int n_pass = 0;
   int mm = 0;
   int dn_a = 0;
   bit mv = 1'b0;

   int m_lvl[2], m_tgt[2], m_wait[2];
   bit m_busy[2], m_done[2], m_ready[2];
   int p_s[2] = '{32, 17};
   bit p_ramp[2] = '{1'b1, 1'b0};

   rcc_div_ramp_if ia ();
   rcc_div_ramp_if ib ();

   assign ia.req_valid = req_valid;
   assign ia.req_sel   = req_sel;
   assign ia.hold      = hold;
   assign ib.req_valid = req_valid;
   assign ib.req_sel   = req_sel;
   assign ib.hold      = hold;

   rcc_div_ramp_ctrl #(.SETTLE_CYC(32), .RAMP_EN(1'b1)) u_a (.i_clk(clk), .rst(rst), .rif(ia.slave));
   rcc_div_ramp_ctrl #(.SETTLE_CYC(17), .RAMP_EN(1'b0)) u_b (.i_clk(clk), .rst(rst), .rif(ib.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // level 0 is code 000; levels 1..4 are codes 4..7
   function automatic int lvl_code(input int lvl);
      return (lvl == 0) ? 0 : lvl + 3;
   endfunction

   task automatic mstep(input int i);
      if (p_ramp[i]) m_lvl[i] = m_lvl[i] + ((m_tgt[i] > m_lvl[i]) ? 1 : -1);
      else m_lvl[i] = m_tgt[i];
      m_wait[i] = p_s[i] - 1;
   endtask

   task automatic model_edge(input int i);
      int tl;
      if (rst) begin
         m_lvl[i] = 0; m_tgt[i] = 0; m_wait[i] = 0;
         m_busy[i] = 0; m_done[i] = 0; m_ready[i] = 0;
         mv = 1'b1;
      end else begin
         m_done[i] = 0;
         if (!m_busy[i]) begin
            if (req_valid && m_ready[i]) begin
               tl = (req_sel < 3'd4) ? 0 : int'(req_sel) - 3;
               m_tgt[i] = tl;
               if (tl == m_lvl[i]) m_done[i] = 1;
               else begin
                  m_busy[i] = 1;
                  if (hold) m_wait[i] = 0;
                  else mstep(i);
               end
            end
         end else if (!hold) begin
            if (m_wait[i] > 0) m_wait[i]--;
            else if (m_lvl[i] != m_tgt[i]) mstep(i);
            else begin m_busy[i] = 0; m_done[i] = 1; end
         end
         m_ready[i] = !m_busy[i];
      end
   endtask

   task automatic cmp(input int i, input logic [2:0] ds, input logic [2:0] cl,
                      input logic bz, input logic dn, input logic rd);
      string nm;
      nm = (i == 0) ? "a" : "b";
      chk({nm, ".div_sel"}, ds, lvl_code(m_lvl[i]));
      chk({nm, ".cur_lvl"}, cl, m_lvl[i]);
      chk({nm, ".busy"}, bz, m_busy[i]);
      chk({nm, ".done"}, dn, m_done[i]);
      chk({nm, ".req_ready"}, rd, m_ready[i]);
   endtask

   // Reference model update at each edge, compared just after the edge
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) model_edge(i);
      #1;
      if (mv) begin
         cmp(0, ia.div_sel, ia.cur_lvl, ia.busy, ia.done, ia.req_ready);
         cmp(1, ib.div_sel, ib.cur_lvl, ib.busy, ib.done, ib.req_ready);
      end
      if (ia.done === 1'b1) dn_a++;
   end

   task automatic adv(input int m);
      repeat (m - mm) @(negedge clk);
      mm = m;
   endtask

   // Present a request at a negedge; returns at the negedge after accept edge T (m=0)
   task automatic req(input logic [2:0] s);
      req_valid = 1'b1;
      req_sel = s;
      mm = -1;
      adv(0);
      req_valid = 1'b0;
   endtask

   logic [2:0] down_seq [4] = '{3'b110, 3'b101, 3'b100, 3'b000};

   initial begin
      repeat (3) @(negedge clk);
      chk("rst.div_sel", ia.div_sel, 3'b000);
      chk("rst.cur_lvl", ia.cur_lvl, 3'd0);
      chk("rst.busy", ia.busy, 1'b0);
      chk("rst.done", ia.done, 1'b0);
      chk("rst.ready_in_rst", ia.req_ready, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst.ready_after", ia.req_ready, 1'b1);

      req(3'b111);
      chk("up.t0", ia.div_sel, 3'b100);
      chk("up.busy0", ia.busy, 1'b1);
      chk("up.ready0", ia.req_ready, 1'b0);
      chk("jump.t0", ib.div_sel, 3'b111);
      adv(16);  chk("jump.busy16", ib.busy, 1'b1);
      adv(17);  chk("jump.done17", ib.done, 1'b1);
      adv(31);  chk("up.t31", ia.div_sel, 3'b100);
      adv(32);  chk("up.t32", ia.div_sel, 3'b101);
      adv(64);  chk("up.t64", ia.div_sel, 3'b110);
      adv(96);  chk("up.t96", ia.div_sel, 3'b111);
      adv(127); chk("up.busy127", ia.busy, 1'b1); chk("up.nodone127", ia.done, 1'b0);
      adv(128); chk("up.done128", ia.done, 1'b1); chk("up.busy128", ia.busy, 1'b0);
      chk("up.lvl", ia.cur_lvl, 3'd4);
      adv(129); chk("up.done129", ia.done, 1'b0);

      dn_a = 0;
      req(3'b000);
      for (int k = 0; k < 4; k++) begin
         adv(32 * k);
         chk("down.step", ia.div_sel, down_seq[k]);
      end
      adv(129);
      chk("down.lvl", ia.cur_lvl, 3'd0);
      chk("down.one_done", dn_a, 1);

      req(3'b010);
      chk("same.done", ia.done, 1'b1);
      chk("same.busy", ia.busy, 1'b0);
      chk("same.div_sel", ia.div_sel, 3'b000);
      adv(1); chk("same.done_off", ia.done, 1'b0);

      req(3'b111);
      adv(39); hold = 1'b1;
      adv(50); chk("hold.ready", ia.req_ready, 1'b0);
      req_valid = 1'b1; req_sel = 3'b000;
      adv(51); req_valid = 1'b0;
      adv(64);  chk("hold.frozen64", ia.div_sel, 3'b101);
      adv(89);  hold = 1'b0;
      adv(113); chk("hold.t113", ia.div_sel, 3'b101);
      adv(114); chk("hold.t114", ia.div_sel, 3'b110);
      adv(146); chk("hold.t146", ia.div_sel, 3'b111);
      adv(178); chk("hold.done", ia.done, 1'b1); chk("hold.lvl", ia.cur_lvl, 3'd4);

      req(3'b000);
      adv(130);
      dn_a = 0;
      req(3'b111);
      adv(39); rst = 1'b1;
      adv(40);
      chk("rmid.div_sel", ia.div_sel, 3'b000);
      chk("rmid.busy", ia.busy, 1'b0);
      chk("rmid.lvl", ia.cur_lvl, 3'd0);
      rst = 1'b0;
      adv(41); chk("rmid.ready", ia.req_ready, 1'b1);
      adv(200); chk("rmid.no_done", dn_a, 0);

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 399) == 0);
         req_valid = ($urandom_range(0, 5) == 0);
         req_sel = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) hold = ~hold;
      end
      rst = 1'b0; hold = 1'b0; req_valid = 1'b0;
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
